// File: rtl/fmps_readout_sequencer_if.sv
// Stream interface carrying FMPS readout entries towards the Mitigation Node path.
//   M_TVALID : beat valid (master -> slave)
//   M_TREADY : beat accepted (slave -> master)
//   M_TDATA  : 32-bit entry data
//   M_TUSER  : {present, index}
//   M_TLAST  : final entry of a completed scan
interface fmps_readout_sequencer_if #(
   parameter int unsigned INDEX_WIDTH = 5
);
   logic                   M_TVALID;
   logic                   M_TREADY;
   logic [31:0]            M_TDATA;
   logic [INDEX_WIDTH:0]   M_TUSER;
   logic                   M_TLAST;

   modport master (output M_TVALID, M_TDATA, M_TUSER, M_TLAST, input M_TREADY);
   modport slave  (input M_TVALID, M_TDATA, M_TUSER, M_TLAST, output M_TREADY);
endinterface

// File: rtl/fmps_readout_sequencer.sv
// FMPS readout sequencer (sysClk domain).
// Sweeps the FMPS readout RAM (1-cycle read latency) after each rising edge of
// readoutValid and streams every entry on mAxis. Single microBlaze diagnostic
// reads share the same read port and are slotted between stream beats.
// Ports:
//   sysClk, sysResetN          : clock, asynchronous active-low reset
//   FAstrobe                   : FA cycle start, aborts a running scan
//   readoutValid, fmpsCount    : scan trigger (rising edge) and entry count
//   fmpsReadoutAddress/-Readout/-ReadoutPresent : shared RAM read port
//   mAxis                      : stream master ({present,index} in TUSER)
//   uBreadStrobe/-Address, uBack/uBdata/uBpresent : microBlaze read port
//   busy, scanDone, scanAbort, abortCount : status
module fmps_readout_sequencer #(
   parameter int unsigned INDEX_WIDTH      = 5,
   parameter int unsigned FMPS_COUNT_WIDTH = INDEX_WIDTH + 1
) (
   input  logic                        sysClk,
   input  logic                        sysResetN,
   input  logic                        FAstrobe,
   input  logic                        readoutValid,
   input  logic [FMPS_COUNT_WIDTH-1:0] fmpsCount,
   output logic [INDEX_WIDTH-1:0]      fmpsReadoutAddress,
   input  logic [31:0]                 fmpsReadout,
   input  logic                        fmpsReadoutPresent,
   fmps_readout_sequencer_if.master    mAxis,
   input  logic                        uBreadStrobe,
   input  logic [INDEX_WIDTH-1:0]      uBreadAddress,
   output logic                        uBack,
   output logic [31:0]                 uBdata,
   output logic                        uBpresent,
   output logic                        busy,
   output logic                        scanDone,
   output logic                        scanAbort,
   output logic [15:0]                 abortCount
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_CAPTURE, S_HOLD, S_UB_ISSUE, S_UB_CAPTURE
   } state_t;

   localparam int unsigned CW = (FMPS_COUNT_WIDTH > INDEX_WIDTH + 1) ? FMPS_COUNT_WIDTH : INDEX_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH = CW'(1) << INDEX_WIDTH;

   state_t                 state, nextState;
   logic [INDEX_WIDTH-1:0] idx, lastIdx, ubAddr, issueIdx, startLastIdx;
   logic [CW-1:0]          countWide;
   logic                   countZero, startCond, abortReq;
   logic                   scanActive, abortFlag, ubPending, rvD;
   logic                   beatValid, beatLast;
   logic [31:0]            beatData;
   logic [INDEX_WIDTH:0]   beatUser;
   logic                   startScan, captureBeat, beatAccept, takeAbort, takeDone, ubCapture;

   assign mAxis.M_TVALID = beatValid;
   assign mAxis.M_TDATA  = beatData;
   assign mAxis.M_TUSER  = beatUser;
   assign mAxis.M_TLAST  = beatLast;
   assign busy           = (state != S_IDLE);

   // Scan length clamped to the RAM depth; stored as the index of the last entry.
   assign countWide    = CW'(fmpsCount);
   assign countZero    = (fmpsCount == '0);
   assign startLastIdx = (countWide > DEPTH) ? INDEX_WIDTH'(DEPTH - 1'b1) : INDEX_WIDTH'(countWide - 1'b1);
   assign startCond    = (state == S_IDLE) && readoutValid && !rvD && !FAstrobe;
   assign abortReq     = FAstrobe || abortFlag;
   assign issueIdx     = startScan ? '0 : idx + 1'b1;

   always_ff @(posedge sysClk or negedge sysResetN) begin
      if (!sysResetN) state <= S_IDLE;
      else            state <= nextState;
   end

   always_comb begin
      nextState   = state;
      startScan   = 1'b0;
      captureBeat = 1'b0;
      beatAccept  = 1'b0;
      takeAbort   = 1'b0;
      takeDone    = 1'b0;
      ubCapture   = 1'b0;
      case (state)
         S_IDLE: begin
            if (startCond) begin
               if (countZero) takeDone = 1'b1;
               else begin
                  nextState = S_ISSUE;
                  startScan = 1'b1;
               end
            end else if (ubPending) begin
               nextState = S_UB_ISSUE;
            end
         end
         S_ISSUE: begin
            if (abortReq) begin
               nextState = S_IDLE;
               takeAbort = 1'b1;
            end else nextState = S_CAPTURE;
         end
         S_CAPTURE: begin
            // An abort here drops the entry being read; nothing is on the bus yet.
            if (abortReq) begin
               nextState = S_IDLE;
               takeAbort = 1'b1;
            end else begin
               nextState   = S_HOLD;
               captureBeat = 1'b1;
            end
         end
         S_HOLD: begin
            if (mAxis.M_TREADY) begin
               beatAccept = 1'b1;
               if (abortReq) begin
                  nextState = S_IDLE;
                  takeAbort = 1'b1;
               end else if (beatLast) begin
                  nextState = S_IDLE;
                  takeDone  = 1'b1;
               end else if (ubPending) nextState = S_UB_ISSUE;
               else                    nextState = S_ISSUE;
            end
         end
         S_UB_ISSUE: nextState = S_UB_CAPTURE;
         S_UB_CAPTURE: begin
            ubCapture = 1'b1;
            if (scanActive && !abortReq) nextState = S_ISSUE;
            else begin
               nextState = S_IDLE;
               takeAbort = scanActive;
            end
         end
         default: nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge sysClk or negedge sysResetN) begin
      if (!sysResetN) begin
         rvD                <= 1'b0;
         scanActive         <= 1'b0;
         abortFlag          <= 1'b0;
         ubPending          <= 1'b0;
         ubAddr             <= '0;
         idx                <= '0;
         lastIdx            <= '0;
         fmpsReadoutAddress <= '0;
         beatValid          <= 1'b0;
         beatLast           <= 1'b0;
         beatData           <= '0;
         beatUser           <= '0;
         uBack              <= 1'b0;
         uBdata             <= '0;
         uBpresent          <= 1'b0;
         scanDone           <= 1'b0;
         scanAbort          <= 1'b0;
         abortCount         <= '0;
      end else begin
         rvD <= readoutValid;

         if (startScan) begin
            scanActive <= 1'b1;
            lastIdx    <= startLastIdx;
         end else if (nextState == S_IDLE) begin
            scanActive <= 1'b0;
         end

         if (nextState == S_IDLE)          abortFlag <= 1'b0;
         else if (FAstrobe && scanActive)  abortFlag <= 1'b1;

         // A strobe in the same cycle the pending request is consumed re-arms it.
         if (uBreadStrobe) begin
            ubPending <= 1'b1;
            ubAddr    <= uBreadAddress;
         end else if (nextState == S_UB_ISSUE) begin
            ubPending <= 1'b0;
         end

         if (nextState == S_ISSUE) begin
            idx                <= issueIdx;
            fmpsReadoutAddress <= issueIdx;
         end else if (nextState == S_UB_ISSUE) begin
            fmpsReadoutAddress <= ubAddr;
         end

         if (captureBeat) begin
            beatValid <= 1'b1;
            beatData  <= fmpsReadout;
            beatUser  <= {fmpsReadoutPresent, idx};
            beatLast  <= (idx == lastIdx);
         end else if (beatAccept) begin
            beatValid <= 1'b0;
            beatLast  <= 1'b0;
         end

         uBack <= ubCapture;
         if (ubCapture) begin
            uBdata    <= fmpsReadout;
            uBpresent <= fmpsReadoutPresent;
         end

         scanDone  <= takeDone;
         scanAbort <= takeAbort;
         if (takeAbort && abortCount != '1) abortCount <= abortCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_fmps_readout_sequencer.sv
// Directed bench for fmps_readout_sequencer with a behavioural 1-cycle-latency
// readout RAM: entry i holds data 0xA0000000 + i*0x1011, present = (i % 3 != 0).
module tb_fmps_readout_sequencer;
   logic        sysClk = 1'b0;
   logic        sysResetN, FAstrobe, readoutValid, uBreadStrobe;
   logic [5:0]  fmpsCount;
   logic [4:0]  fmpsReadoutAddress, uBreadAddress;
   logic [31:0] fmpsReadout, uBdata;
   logic        fmpsReadoutPresent, uBack, uBpresent, busy, scanDone, scanAbort;
   logic [15:0] abortCount;

   int checks   = 0;
   int failures = 0;
   int ackCnt   = 0;
   logic [4:0]  qIdx[$];
   logic        qPres[$], qLast[$];
   logic [31:0] qData[$];

   fmps_readout_sequencer_if #(.INDEX_WIDTH(5)) axis ();

   fmps_readout_sequencer #(.INDEX_WIDTH(5), .FMPS_COUNT_WIDTH(6)) dut (
      .sysClk(sysClk), .sysResetN(sysResetN), .FAstrobe(FAstrobe),
      .readoutValid(readoutValid), .fmpsCount(fmpsCount),
      .fmpsReadoutAddress(fmpsReadoutAddress), .fmpsReadout(fmpsReadout),
      .fmpsReadoutPresent(fmpsReadoutPresent), .mAxis(axis.master),
      .uBreadStrobe(uBreadStrobe), .uBreadAddress(uBreadAddress),
      .uBack(uBack), .uBdata(uBdata), .uBpresent(uBpresent), .busy(busy),
      .scanDone(scanDone), .scanAbort(scanAbort), .abortCount(abortCount)
   );

   always #5 sysClk = ~sysClk;

   function automatic logic [31:0] memData(input int i);
      return 32'hA000_0000 + 32'(i) * 32'h0000_1011;
   endfunction

   function automatic logic memPres(input int i);
      return (i % 3) != 0;
   endfunction

   always @(posedge sysClk) begin
      fmpsReadout        <= memData(int'(fmpsReadoutAddress));
      fmpsReadoutPresent <= memPres(int'(fmpsReadoutAddress));
   end

   always @(posedge sysClk) begin
      if (sysResetN) begin
         if (axis.M_TVALID && axis.M_TREADY) begin
            qIdx.push_back(axis.M_TUSER[4:0]);
            qPres.push_back(axis.M_TUSER[5]);
            qData.push_back(axis.M_TDATA);
            qLast.push_back(axis.M_TLAST);
         end
         if (uBack) ackCnt++;
      end
   end

   task automatic tick();
      @(posedge sysClk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clearBeats();
      qIdx.delete(); qPres.delete(); qData.delete(); qLast.delete();
   endtask

   // Every recorded beat must be entry i in order; TLAST only on the final one when a scan completes.
   task automatic checkBeats(input string tag, input int n, input logic lastOnFinal);
      check({tag, "_count"}, 64'(qIdx.size()), 64'(n));
      for (int i = 0; i < qIdx.size(); i++) begin
         check($sformatf("%s_idx%0d", tag, i), 64'(qIdx[i]), 64'(i));
         check($sformatf("%s_data%0d", tag, i), 64'(qData[i]), 64'(memData(i)));
         check($sformatf("%s_pres%0d", tag, i), 64'(qPres[i]), 64'(memPres(i)));
         check($sformatf("%s_last%0d", tag, i), 64'(qLast[i]), 64'(lastOnFinal && (i == n - 1)));
      end
   endtask

   task automatic waitDone(input string tag, input int budget);
      int n = 0;
      while (scanDone !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_scanDone"}, 64'(scanDone), 64'(1));
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_tvalid"}, 64'(axis.M_TVALID), 64'(0));
      check({tag, "_tdata"}, 64'(axis.M_TDATA), 64'(0));
      check({tag, "_tuser"}, 64'(axis.M_TUSER), 64'(0));
      check({tag, "_tlast"}, 64'(axis.M_TLAST), 64'(0));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_flags"}, 64'({scanDone, scanAbort, uBack, uBpresent}), 64'(0));
      check({tag, "_abortCount"}, 64'(abortCount), 64'(0));
      check({tag, "_addr"}, 64'(fmpsReadoutAddress), 64'(0));
      check({tag, "_uBdata"}, 64'(uBdata), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sysResetN = 1'b0; FAstrobe = 1'b0; readoutValid = 1'b0; uBreadStrobe = 1'b0;
      uBreadAddress = '0; fmpsCount = '0; axis.M_TREADY = 1'b0;
      ticks(2);
      checkAllZero("reset");
      sysResetN = 1'b1;
      tick();

      // Basic 4-entry scan, ready always high
      fmpsCount = 6'd4; axis.M_TREADY = 1'b1; clearBeats();
      readoutValid = 1'b1;                                   // cycle E
      tick(); check("t1_tvalid_E1", 64'(axis.M_TVALID), 64'(0));
      check("t1_busy_E1", 64'(busy), 64'(1));
      check("t1_addr_E1", 64'(fmpsReadoutAddress), 64'(0));
      tick(); check("t1_tvalid_E2", 64'(axis.M_TVALID), 64'(0));
      tick(); check("t1_tvalid_E3", 64'(axis.M_TVALID), 64'(1));
      check("t1_tuser_E3", 64'(axis.M_TUSER), 64'(6'h00));
      check("t1_tdata_E3", 64'(axis.M_TDATA), 64'(32'hA000_0000));
      ticks(9);                                              // E+12
      check("t1_tlast_E12", 64'(axis.M_TLAST), 64'(1));
      check("t1_tuser_E12", 64'(axis.M_TUSER), 64'(6'h03));
      check("t1_done_E12", 64'(scanDone), 64'(0));
      tick();                                                // E+13
      check("t1_done_E13", 64'(scanDone), 64'(1));
      check("t1_busy_E13", 64'(busy), 64'(0));
      readoutValid = 1'b0;
      checkBeats("t1", 4, 1'b1);
      tick();

      // Backpressure on beat 1
      fmpsCount = 6'd3; clearBeats();
      readoutValid = 1'b1;
      ticks(6);                                              // E+6: beat 1 held
      check("t2_tuser_E6", 64'(axis.M_TUSER), 64'(6'h21));
      axis.M_TREADY = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("t2_stall_tvalid%0d", k), 64'(axis.M_TVALID), 64'(1));
         check($sformatf("t2_stall_tdata%0d", k), 64'(axis.M_TDATA), 64'(memData(1)));
         check($sformatf("t2_stall_tuser%0d", k), 64'(axis.M_TUSER), 64'(6'h21));
         check($sformatf("t2_stall_addr%0d", k), 64'(fmpsReadoutAddress), 64'(1));
      end
      axis.M_TREADY = 1'b1; readoutValid = 1'b0;
      waitDone("t2", 30);
      checkBeats("t2", 3, 1'b1);
      tick();

      // microBlaze reads while idle: back-to-back strobes, second lands as pending clears
      ackCnt = 0;
      uBreadStrobe = 1'b1; uBreadAddress = 5'd5;             // X
      tick(); uBreadAddress = 5'd9;                          // X+1
      tick(); uBreadStrobe = 1'b0;                           // X+2
      check("ub_addr5", 64'(fmpsReadoutAddress), 64'(5));
      ticks(2);                                              // X+4
      check("ub_ack1", 64'(uBack), 64'(1));
      check("ub_data5", 64'(uBdata), 64'(memData(5)));
      check("ub_pres5", 64'(uBpresent), 64'(1));
      tick();                                                // X+5
      check("ub_ack1_off", 64'(uBack), 64'(0));
      check("ub_addr9", 64'(fmpsReadoutAddress), 64'(9));
      ticks(2);                                              // X+7
      check("ub_ack2", 64'(uBack), 64'(1));
      check("ub_data9", 64'(uBdata), 64'(memData(9)));
      check("ub_pres9", 64'(uBpresent), 64'(0));
      tick();
      check("ub_ackCnt", 64'(ackCnt), 64'(2));

      // microBlaze read interleaved into a scan
      fmpsCount = 6'd8; clearBeats(); ackCnt = 0;
      readoutValid = 1'b1;
      ticks(9);                                              // E+9: beat 2 held
      check("t3_tuser_E9", 64'(axis.M_TUSER), 64'(6'h22));
      axis.M_TREADY = 1'b0; uBreadStrobe = 1'b1; uBreadAddress = 5'd7;
      tick(); uBreadStrobe = 1'b0; axis.M_TREADY = 1'b1;     // E+10
      tick();                                                // E+11
      check("t3_ub_addr", 64'(fmpsReadoutAddress), 64'(7));
      check("t3_tvalid_E11", 64'(axis.M_TVALID), 64'(0));
      tick(); check("t3_ack_E12", 64'(uBack), 64'(0));
      tick();                                                // E+13
      check("t3_ack_E13", 64'(uBack), 64'(1));
      check("t3_ubdata", 64'(uBdata), 64'(memData(7)));
      check("t3_ubpres", 64'(uBpresent), 64'(1));
      check("t3_resume_addr", 64'(fmpsReadoutAddress), 64'(3));
      readoutValid = 1'b0;
      waitDone("t3", 40);
      checkBeats("t3", 8, 1'b1);
      check("t3_ackCnt", 64'(ackCnt), 64'(1));
      tick();

      // Abort while beat 2 is held
      clearBeats();
      readoutValid = 1'b1;
      ticks(9);                                              // E+9
      axis.M_TREADY = 1'b0; FAstrobe = 1'b1;
      tick(); FAstrobe = 1'b0;                               // E+10
      check("t4_held_tvalid", 64'(axis.M_TVALID), 64'(1));
      check("t4_held_tuser", 64'(axis.M_TUSER), 64'(6'h22));
      axis.M_TREADY = 1'b1;
      tick();                                                // E+11
      check("t4_scanAbort", 64'(scanAbort), 64'(1));
      check("t4_busy", 64'(busy), 64'(0));
      check("t4_abortCount", 64'(abortCount), 64'(1));
      check("t4_tvalid", 64'(axis.M_TVALID), 64'(0));
      tick(); check("t4_scanAbort_pulse", 64'(scanAbort), 64'(0));
      checkBeats("t4", 3, 1'b0);
      readoutValid = 1'b0; clearBeats();
      tick(); readoutValid = 1'b1;
      ticks(3);
      check("t4_restart_tvalid", 64'(axis.M_TVALID), 64'(1));
      check("t4_restart_tuser", 64'(axis.M_TUSER), 64'(6'h00));
      readoutValid = 1'b0;
      waitDone("t4_restart", 40);
      checkBeats("t4r", 8, 1'b1);
      tick();

      // Zero-length scan, then a count beyond the RAM depth
      fmpsCount = 6'd0; clearBeats();
      readoutValid = 1'b1;
      tick();
      check("t5_zero_done", 64'(scanDone), 64'(1));
      check("t5_zero_busy", 64'(busy), 64'(0));
      tick();
      check("t5_zero_done_pulse", 64'(scanDone), 64'(0));
      check("t5_zero_tvalid", 64'(axis.M_TVALID), 64'(0));
      check("t5_zero_beats", 64'(qIdx.size()), 64'(0));
      readoutValid = 1'b0; fmpsCount = 6'd40;
      tick(); readoutValid = 1'b1;
      waitDone("t5_clamp", 200);
      readoutValid = 1'b0;
      checkBeats("t5", 32, 1'b1);
      tick();

      // Asynchronous reset while a beat is held
      fmpsCount = 6'd4; clearBeats(); axis.M_TREADY = 1'b0;
      readoutValid = 1'b1;
      ticks(3);
      check("t6_tvalid_before", 64'(axis.M_TVALID), 64'(1));
      #2 sysResetN = 1'b0;
      #1 checkAllZero("t6_async");
      readoutValid = 1'b0; axis.M_TREADY = 1'b1; clearBeats();
      tick();
      sysResetN = 1'b1;
      tick(); readoutValid = 1'b1;
      waitDone("t6", 40);
      readoutValid = 1'b0;
      checkBeats("t6", 4, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
